// File: rtl/pipeline_merge_arbiter.sv
// Two-input merge arbiter: one FIFO per pipeline, round-robin merge onto a single
// valid/ready port, registered per-pipeline stall and sticky overflow flags.
// Optional feature macro STALL_COUNTERS_EN adds saturating stall-cycle counters.
module pipeline_merge_arbiter #(
  parameter int unsigned DW           = 32,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STALL_MARGIN = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p1_valid_i,
  input  logic [DW-1:0] p1_data_i,
  input  logic          p1_flush_i,
  input  logic          p2_valid_i,
  input  logic [DW-1:0] p2_data_i,
  input  logic          p2_flush_i,
  input  logic          out_ready_i,
  output logic          out_valid_o,
  output logic [DW-1:0] out_data_o,
  output logic          out_src_o,
  output logic          stall_1_o,
  output logic          stall_2_o,
`ifdef STALL_COUNTERS_EN
  output logic [31:0]   stall_cnt_1_o,
  output logic [31:0]   stall_cnt_2_o,
`endif
  output logic [1:0]    overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC    = CW'(DEPTH);
  localparam logic [CW-1:0] StallThrC = CW'(DEPTH - STALL_MARGIN);

  typedef enum logic {StIdle, StHold} state_e;

  logic [1:0]    valid_in, flush_in;
  logic [DW-1:0] data_in [2];

  logic [DW-1:0] mem_q  [2][DEPTH];
  logic [AW-1:0] wptr_q [2];
  logic [AW-1:0] rptr_q [2];
  logic [CW-1:0] cnt_q  [2];
  logic [CW-1:0] cnt_d  [2];
  logic [1:0]    push, pop, drop, nonempty;
  logic [1:0]    stall_q, ovf_q;

  state_e state_q, state_d;
  logic   sel_q, sel_d, rr_q, rr_d;
  logic   sel, xfer;

  assign valid_in   = {p2_valid_i, p1_valid_i};
  assign flush_in   = {p2_flush_i, p1_flush_i};
  assign data_in[0] = p1_data_i;
  assign data_in[1] = p2_data_i;

  // Push/pop/drop decisions and next occupancy; a flush wins over any same-cycle access.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      nonempty[i] = (cnt_q[i] != '0);
      pop[i]      = xfer && (sel == 1'(i)) && !flush_in[i];
      push[i]     = valid_in[i] && !flush_in[i] && ((cnt_q[i] < DepthC) || pop[i]);
      drop[i]     = valid_in[i] && !flush_in[i] && !push[i];
      cnt_d[i]    = flush_in[i] ? '0 : cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
    end
  end

  // FIFO pointers, occupancy, registered stall and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      stall_q <= '0;
      ovf_q   <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        cnt_q[i]   <= cnt_d[i];
        stall_q[i] <= (cnt_d[i] >= StallThrC);
        if (drop[i]) ovf_q[i] <= 1'b1;
        if (flush_in[i]) begin
          wptr_q[i] <= '0;
          rptr_q[i] <= '0;
        end else begin
          if (push[i]) wptr_q[i] <= wptr_q[i] + 1'b1;
          if (pop[i])  rptr_q[i] <= rptr_q[i] + 1'b1;
        end
      end
    end
  end

  // Storage array; contents are only visible through out_valid-gated reads.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem_q[i][wptr_q[i]] <= data_in[i];
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      sel_q   <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
    end
  end

  // Arbiter next state: hold a stalled offer unless its FIFO is flushed.
  always_comb begin
    state_d = (out_valid_o && !out_ready_i && !flush_in[sel]) ? StHold : StIdle;
    sel_d   = sel;
    rr_d    = xfer ? ~sel : rr_q;
  end

  // Arbiter outputs: selection and the merged port; with nothing pending sel stays on rr.
  always_comb begin
    sel = rr_q;
    if (state_q == StHold) sel = sel_q;
    else if (!nonempty[rr_q] && nonempty[~rr_q]) sel = ~rr_q;
    out_valid_o = nonempty[sel];
    out_data_o  = out_valid_o ? mem_q[sel][rptr_q[sel]] : '0;
    out_src_o   = sel;
    xfer        = out_valid_o && out_ready_i;
  end

  assign stall_1_o  = stall_q[0];
  assign stall_2_o  = stall_q[1];
  assign overflow_o = ovf_q;

`ifdef STALL_COUNTERS_EN
  logic [31:0] scnt_q [2];

  // Saturating count of cycles spent with each stall asserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scnt_q[0] <= '0;
      scnt_q[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (stall_q[i] && (scnt_q[i] != '1)) scnt_q[i] <= scnt_q[i] + 32'd1;
      end
    end
  end

  assign stall_cnt_1_o = scnt_q[0];
  assign stall_cnt_2_o = scnt_q[1];
`endif

endmodule

// File: tb/tb_pipeline_merge_arbiter.sv
// Randomized bench for pipeline_merge_arbiter against a queue-based reference model.
module tb_pipeline_merge_arbiter;

  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int MARGIN = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          p1_valid, p1_flush, p2_valid, p2_flush, out_ready;
  logic [DW-1:0] p1_data, p2_data;
  logic          out_valid, out_src, stall_1, stall_2;
  logic [DW-1:0] out_data;
  logic [1:0]    overflow;
`ifdef STALL_COUNTERS_EN
  logic [31:0]   stall_cnt_1, stall_cnt_2;
`endif

  pipeline_merge_arbiter #(.DW(DW), .DEPTH(DEPTH), .STALL_MARGIN(MARGIN)) dut (
    .clk         (clk),
    .reset       (reset),
    .p1_valid_i  (p1_valid),
    .p1_data_i   (p1_data),
    .p1_flush_i  (p1_flush),
    .p2_valid_i  (p2_valid),
    .p2_data_i   (p2_data),
    .p2_flush_i  (p2_flush),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_src_o   (out_src),
    .stall_1_o   (stall_1),
    .stall_2_o   (stall_2),
`ifdef STALL_COUNTERS_EN
    .stall_cnt_1_o (stall_cnt_1),
    .stall_cnt_2_o (stall_cnt_2),
`endif
    .overflow_o  (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one queue per pipeline plus the arbitration rules.
  logic [DW-1:0] mq [2][$];
  bit            m_rr, m_held, m_hsel;
  bit [1:0]      m_stall, m_ovf;
  longint        m_scnt [2];

  task automatic model_reset();
    mq[0].delete();
    mq[1].delete();
    m_rr = 0; m_held = 0; m_hsel = 0;
    m_stall = '0; m_ovf = '0;
    m_scnt[0] = 0; m_scnt[1] = 0;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    check_eq("rst_out_src", 64'(out_src), 64'd0);
    check_eq("rst_stall", 64'({stall_2, stall_1}), 64'd0);
    check_eq("rst_overflow", 64'(overflow), 64'd0);
  endtask

  task automatic drive_idle();
    p1_valid = 0; p2_valid = 0; p1_flush = 0; p2_flush = 0; out_ready = 0;
    p1_data = '0; p2_data = '0;
  endtask

  // One cycle: compare model's view of the outputs, then advance the model.
  task automatic step_and_check();
    bit            sel, ev, xfer;
    logic [DW-1:0] ed;
    bit [1:0]      vin, fin;
    logic [DW-1:0] din [2];
    vin = {p2_valid, p1_valid};
    fin = {p2_flush, p1_flush};
    din[0] = p1_data;
    din[1] = p2_data;
    if (m_held) sel = m_hsel;
    else if (mq[m_rr].size() != 0) sel = m_rr;
    else if (mq[!m_rr].size() != 0) sel = !m_rr;
    else sel = m_rr;
    ev = (mq[sel].size() != 0);
    ed = ev ? mq[sel][0] : '0;
    check_eq("out_valid", 64'(out_valid), 64'(ev));
    check_eq("out_data", 64'(out_data), 64'(ed));
    if (ev) check_eq("out_src", 64'(out_src), 64'(sel));
    check_eq("stall", 64'({stall_2, stall_1}), 64'(m_stall));
    check_eq("overflow", 64'(overflow), 64'(m_ovf));
`ifdef STALL_COUNTERS_EN
    check_eq("stall_cnt_1", 64'(stall_cnt_1), 64'(m_scnt[0]));
    check_eq("stall_cnt_2", 64'(stall_cnt_2), 64'(m_scnt[1]));
    for (int i = 0; i < 2; i++) if (m_stall[i] && m_scnt[i] < 64'hFFFF_FFFF) m_scnt[i]++;
`endif
    xfer = ev && out_ready;
    for (int i = 0; i < 2; i++) begin
      if (fin[i]) begin
        mq[i].delete();
      end else begin
        if (xfer && sel == 1'(i)) void'(mq[i].pop_front());
        if (vin[i]) begin
          if (mq[i].size() < DEPTH) mq[i].push_back(din[i]);
          else m_ovf[i] = 1'b1;
        end
      end
      m_stall[i] = (mq[i].size() >= DEPTH - MARGIN);
    end
    m_held = ev && !out_ready && !fin[sel];
    m_hsel = sel;
    if (xfer) m_rr = !sel;
  endtask

  int vpct [4] = '{90, 70, 60, 95};
  int rpct [4] = '{95, 30, 10, 60};
  int fpct [4] = '{0, 3, 6, 2};

  initial begin
    drive_idle();
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;

    // Directed opener: two p1 words drained at full rate.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive_idle();
      out_ready = 1;
      if (c < 2) begin p1_valid = 1; p1_data = (c == 0) ? 32'h10 : 32'h12; end
      #1 step_and_check();
    end

    for (int cyc = 0; cyc < 3000; cyc++) begin
      int ph;
      ph = (cyc / 250) % 4;
      @(negedge clk);
      if (cyc == 1600) begin
        // Asynchronous reset mid-operation: outputs must clear without a clock edge.
        reset = 1'b1;
        drive_idle();
        #1 check_reset_outputs();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
      end
      p1_valid  = ($urandom_range(99) < 32'(vpct[ph]));
      p2_valid  = ($urandom_range(99) < 32'(vpct[ph]));
      p1_data   = $urandom;
      p2_data   = $urandom;
      out_ready = ($urandom_range(99) < 32'(rpct[ph]));
      p1_flush  = ($urandom_range(99) < 32'(fpct[ph]));
      p2_flush  = ($urandom_range(99) < 32'(fpct[ph]));
      #1 step_and_check();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
